muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
Iterative sequencer for the RV32M multiply/divide instructions in the execute stage of the pipelined core. It sits beside the single-cycle ALU.
- Accepts operands from the ID/EX register.
- Runs a 32-step shift-add multiply or restoring divide.
- Holds the pipeline via Stall until the result is ready.
- Presents the result for one cycle so the EX/MEM register captures it.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, synchronous, active-high
Start  input  1  M-extension instruction valid in EX
Op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
SrcA  input  DATA_WIDTH  rs1 operand (post-forwarding)
SrcB  input  DATA_WIDTH  rs2 operand (post-forwarding)
Flush  input  1  kill in-flight operation (branch mispredict/trap)
Stall  output  1  freeze IF/ID/EX, combinational
Busy  output  1  iteration in progress
Done  output  1  one-cycle result-valid pulse
Result  output  DATA_WIDTH  selected 32-bit result

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE, counter 0, Busy=0, Done=0, Result=0, internal registers cleared. Reset mid-operation aborts with no Done.
- FSM states: IDLE, CALC, DONE.
- Busy = (state==CALC).
- Stall = (state==IDLE & Start & ~Flush) | (state==CALC).
- Done = (state==DONE), registered.
- IDLE:
  - Start & ~Flush at edge: latch Op, sign flags and operand magnitudes.
  - Normal case: go to CALC with counter=0.
  - Special divide cases go straight to DONE.
  - Start=0: remain in IDLE.
- Cycle timing: Start sampled in cycle 0 → CALC in cycles 1..32 (counter 0..31) → DONE in cycle 33, with Done=1 and Result valid. Next cycle returns to IDLE. Stall=0 in DONE, so the pipeline advances with the result.
- Back-to-back operations: a new Start is accepted only in IDLE. A following M-instruction therefore starts one cycle after DONE.
- Start while in CALC or DONE is ignored.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: SrcA signed, SrcB unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - The core always operates on unsigned magnitudes.
- Multiply:
  - 64-bit accumulator; each CALC cycle adds the shifted multiplicand when the current multiplier bit is 1.
  - Sign fix on the DONE transition: negate the 64-bit product if signA^signB (signed cases only).
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide:
  - Restoring divide; one quotient bit per cycle, MSB first.
  - Quotient negated if signA^signB; remainder takes the sign of the dividend.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases (IDLE→DONE, Done in cycle 1, no CALC):
  - Divide by zero: quotient 0xFFFFFFFF, remainder = SrcA.
  - Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM only): quotient 0x80000000, remainder 0.
- Result is written only on entry to DONE and holds its value afterward until the next completion.
- Flush:
  - Flush=1 in any state: next state IDLE, no Done, Result unchanged.
  - Flush has priority over Start.
  - Flush in DONE still lets the Done pulse in that cycle complete; the consumer handles the kill.
- Arithmetic uses full 64-bit intermediates; no truncation before the final select.

Test Plan:
- Reset then MUL 7 × 0xFFFFFFFD (Start in cycle 0) → Stall 1 in cycles 0–32, Done=1 only in cycle 33, Result 0xFFFFFFEB; Stall 0 in cycle 33.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD; REM of the same operands → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 0x1234 / 0 → 0xFFFFFFFF with Done in cycle 1; REM 0x1234 / 0 → 0x1234; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 and REM → 0, both with Done in cycle 1.
- Start a DIV, assert Flush in cycle 10 → IDLE in cycle 11, Busy/Stall 0, Done never asserted, Result keeps its prior value. Repeat with rst in cycle 10 → all outputs 0.
- Back-to-back MUL then DIV with Start held high → second op accepted in cycle 34, its Done in cycle 67. Start pulses during CALC have no effect.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer for the execute stage.
// Runs a DATA_WIDTH-step shift-add multiply or restoring divide on unsigned
// magnitudes, applies the sign fix on completion, and pulses Done with Result.
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   Start, Op        M-instruction valid in EX and its funct3
//   SrcA, SrcB       rs1/rs2 operands after forwarding
//   Flush            kill any in-flight operation
//   Stall            combinational pipeline freeze request
//   Busy, Done       iteration in progress / one-cycle result-valid pulse
//   Result           selected result, held until the next completion
module muldiv_seq #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [2:0]            Op,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  Flush,
  output logic                  Stall,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result
);

  localparam int unsigned W      = DATA_WIDTH;
  localparam int unsigned CNT_W  = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [W-1:0]     MOST_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;      // product/quotient must be negated
  logic               rneg_q, rneg_d;    // remainder takes dividend sign
  logic [2*W-1:0]     acc_q, acc_d;      // mul: product; div: {remainder, dividend/quotient}
  logic [2*W-1:0]     mcand_q, mcand_d;  // multiplicand shifted left each step
  logic [W-1:0]       bmag_q, bmag_d;    // multiplier (mul) or divisor (div)
  logic [W-1:0]       result_q, result_d;

  // Operand signedness from funct3
  logic a_signed, b_signed;
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (Op)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
  end

  logic         sign_a, sign_b;
  logic [W-1:0] a_mag, b_mag;
  logic         div_by_zero, div_ovf;

  assign sign_a      = a_signed & SrcA[W-1];
  assign sign_b      = b_signed & SrcB[W-1];
  assign a_mag       = sign_a ? (-SrcA) : SrcA;
  assign b_mag       = sign_b ? (-SrcB) : SrcB;
  assign div_by_zero = Op[2] & (SrcB == '0);
  assign div_ovf     = Op[2] & ~Op[0] & (SrcA == MOST_NEG) & (SrcB == '1);

  // One multiply step: add shifted multiplicand when the current multiplier bit is set
  logic [2*W-1:0] mul_acc;
  assign mul_acc = acc_q + (bmag_q[cnt_q] ? mcand_q : '0);

  // One restoring-divide step: shift in next dividend bit, subtract if it fits
  logic [W:0]     rem_shift;
  logic           div_ge;
  logic [W-1:0]   rem_new;
  logic [2*W-1:0] div_acc;
  assign rem_shift = acc_q[2*W-1:W-1];
  assign div_ge    = rem_shift >= {1'b0, bmag_q};
  assign rem_new   = div_ge ? W'(rem_shift - {1'b0, bmag_q}) : rem_shift[W-1:0];
  assign div_acc   = {rem_new, acc_q[W-2:0], div_ge};

  // Sign fix and final select, used on the last CALC step
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rmd, final_res;
  assign prod = neg_q ? (-mul_acc) : mul_acc;
  assign quo  = neg_q ? (-div_acc[W-1:0]) : div_acc[W-1:0];
  assign rmd  = rneg_q ? (-div_acc[2*W-1:W]) : div_acc[2*W-1:W];
  always_comb begin
    if (op_q[2])                final_res = op_q[1] ? rmd : quo;
    else if (op_q[1:0] == 2'b00) final_res = prod[W-1:0];
    else                         final_res = prod[2*W-1:W];
  end

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    bmag_d   = bmag_q;
    result_d = result_q;

    case (state_q)
      IDLE: begin
        if (Start && !Flush) begin
          op_d    = Op;
          neg_d   = sign_a ^ sign_b;
          rneg_d  = sign_a;
          bmag_d  = b_mag;
          mcand_d = {{W{1'b0}}, a_mag};
          acc_d   = Op[2] ? {{W{1'b0}}, a_mag} : '0;
          cnt_d   = '0;
          if (div_by_zero) begin
            state_d  = DONE;
            result_d = Op[1] ? SrcA : '1;
          end else if (div_ovf) begin
            state_d  = DONE;
            result_d = Op[1] ? '0 : MOST_NEG;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d   = op_q[2] ? div_acc : mul_acc;
        mcand_d = mcand_q << 1;
        cnt_d   = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == LAST_CNT) begin
          state_d  = DONE;
          result_d = final_res;
          cnt_d    = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Kill wins over everything; the held result is left untouched
    if (Flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      bmag_q   <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      bmag_q   <= bmag_d;
      result_q <= result_d;
    end
  end

  assign Busy   = (state_q == CALC);
  assign Done   = (state_q == DONE);
  assign Result = result_q;
  assign Stall  = ((state_q == IDLE) & Start & ~Flush) | (state_q == CALC);

endmodule

// File: tb/tb_muldiv_seq.sv
// Testbench for muldiv_seq: directed plan cases plus randomized traffic,
// compared every cycle against a cycle-count based behavioural model.
module tb_muldiv_seq;
  localparam int unsigned W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         rst, Start, Flush;
  logic [2:0]   Op;
  logic [W-1:0] SrcA, SrcB;
  logic         Stall, Busy, Done;
  logic [W-1:0] Result;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .Flush(Flush), .Stall(Stall), .Busy(Busy), .Done(Done), .Result(Result)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Architectural result of an RV32M op, from plain 64-bit arithmetic
  function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    r  = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); r = p[31:0]; end
      3'd1: begin p = 64'(sa * sb); r = p[63:32]; end
      3'd2: begin p = 64'(sa * ub); r = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic bit is_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && (b == 0 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF));
  endfunction

  // Behavioural model: remaining iteration cycles, done pulse, held result
  int          m_left = 0;
  bit          m_done = 1'b0;
  bit          m_idle;
  logic [31:0] m_result = '0;
  logic [31:0] m_pend   = '0;
  bit          chk_en   = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_result = '0;
    end else if (Flush) begin
      m_left = 0; m_done = 1'b0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_done = 1'b1; m_result = m_pend; end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (Start) begin
      m_pend = ref_op(Op, SrcA, SrcB);
      if (is_fast(Op, SrcA, SrcB)) begin m_done = 1'b1; m_result = m_pend; end
      else m_left = W;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      m_idle = (m_left == 0) && !m_done;
      chk("busy",   64'(Busy),   64'(m_left > 0));
      chk("done",   64'(Done),   64'(m_done));
      chk("stall",  64'(Stall),  64'((m_idle && Start && !Flush) || m_left > 0));
      chk("result", 64'(Result), 64'(m_result));
    end
  end

  // Start in cycle 0, drop Start, wait for Done; checks latency and result
  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
    int lat = 0;
    @(posedge clk); #1; Start = 1'b1; Op = op; SrcA = a; SrcB = b;
    do begin
      @(posedge clk); #1; Start = 1'b0; lat++;
    end while (!Done && lat < 100);
    chk({nm, "_lat"},   64'(lat), 64'(exp_lat));
    chk({nm, "_res"},   64'(Result), 64'(exp_res));
    chk({nm, "_stall"}, 64'(Stall), 64'(0));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return MIN;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  int done_seen, first_c, second_c;
  logic [31:0] first_r;

  initial begin
    rst = 1'b1; Start = 1'b0; Flush = 1'b0; Op = '0; SrcA = '0; SrcB = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_result", 64'(Result), 64'(0));
    chk("reset_busy",   64'(Busy),   64'(0));

    // Pin the model with hand-computed values
    chk("m_mul",    ref_op(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    chk("m_mulh",   ref_op(3'd1, MIN, MIN), 32'h4000_0000);
    chk("m_mulhsu", ref_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
    chk("m_div",    ref_op(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
    chk("m_divovf", ref_op(3'd4, MIN, 32'hFFFF_FFFF), MIN);

    // Directed plan
    run_op("mul",     3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("mulh",    3'd1, MIN, MIN, 32'h4000_0000, 33);
    run_op("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run_op("div",     3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem",     3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("divu",    3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu",    3'd7, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu0",   3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem0",    3'd6, 32'h1234, 32'd0, 32'h1234, 1);
    run_op("divovf",  3'd4, MIN, 32'hFFFF_FFFF, MIN, 1);
    run_op("removf",  3'd6, MIN, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu_pr", 3'd5, 32'd100, 32'd7, 32'd14, 33);

    // Flush in cycle 10 of a DIV
    @(posedge clk); #1; Start = 1'b1; Op = 3'd4; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk); #1; Start = 1'b0;
    repeat (9) @(posedge clk);
    #1; Flush = 1'b1;
    @(posedge clk); #1; Flush = 1'b0;
    chk("flush_busy",   64'(Busy),   64'(0));
    chk("flush_stall",  64'(Stall),  64'(0));
    chk("flush_result", 64'(Result), 64'(14));
    done_seen = 0;
    repeat (40) begin @(posedge clk); #1; if (Done) done_seen++; end
    chk("flush_nodone", 64'(done_seen), 64'(0));

    // Reset in cycle 10 of a DIV
    @(posedge clk); #1; Start = 1'b1; Op = 3'd4; SrcA = 32'd1000; SrcB = 32'd3;
    @(posedge clk); #1; Start = 1'b0;
    repeat (9) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    chk("rst_busy",   64'(Busy),   64'(0));
    chk("rst_done",   64'(Done),   64'(0));
    chk("rst_stall",  64'(Stall),  64'(0));
    chk("rst_result", 64'(Result), 64'(0));
    done_seen = 0;
    repeat (40) begin @(posedge clk); #1; if (Done) done_seen++; end
    chk("rst_nodone", 64'(done_seen), 64'(0));

    // Back-to-back MUL then DIV with Start held high
    first_c = -1; second_c = -1; first_r = '0;
    @(posedge clk); #1; Start = 1'b1; Op = 3'd0; SrcA = 32'd7; SrcB = 32'hFFFF_FFFD;
    for (int c = 1; c <= 100 && second_c < 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin Op = 3'd4; SrcA = 32'hFFFF_FFF9; SrcB = 32'd2; end
      if (Done) begin
        if (first_c < 0) begin first_c = c; first_r = Result; end
        else begin second_c = c; Start = 1'b0; end
      end
    end
    Start = 1'b0;
    chk("b2b_first_cyc",  64'(first_c),  64'(33));
    chk("b2b_first_res",  64'(first_r),  64'(32'hFFFF_FFEB));
    chk("b2b_second_cyc", 64'(second_c), 64'(67));
    chk("b2b_second_res", 64'(Result),   64'(32'hFFFF_FFFD));

    // Randomized traffic: Start pulses in any state, rare Flush and reset
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      Start = ($urandom_range(0, 2) == 0);
      Op    = 3'($urandom_range(0, 7));
      SrcA  = pick();
      SrcB  = pick();
      Flush = ($urandom_range(0, 199) == 0);
      rst   = ($urandom_range(0, 999) == 0);
    end
    @(posedge clk); #1; Start = 1'b0; Flush = 1'b0; rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
